mano_wbuf: RTL

Four-entry write buffer and memory sequencer between the direct-mapped cache's memory port and the 4096x16 main memory. It absorbs cache write-backs so the cache never waits on memory writes, and forwards buffered data to cache refill reads (read-after-write). It serialises all remaining traffic onto a single req/ack memory port, giving refill reads priority over write drains.

---
 rtl/mano_wbuf_pkg.sv | 21 ++
 rtl/mano_wbuf_lookup.sv | 54 +++++
 rtl/mano_wbuf.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mano_wbuf_pkg.sv
// mano_wbuf_pkg: shared types and sizes for the mano_wbuf write buffer.
//   state_t  - memory sequencer FSM states
//   entry_t  - one buffer entry {valid, addr, data}
//   ADDR_W / DATA_W come from addrwidth / datawidth; DEPTH must be a power of two.
package mano_wbuf_pkg;
  localparam int addrwidth = 12;
  localparam int datawidth = 16;
  localparam int ADDR_W    = addrwidth;
  localparam int DATA_W    = datawidth;
  localparam int DEPTH     = 4;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/mano_wbuf_lookup.sv
// mano_wbuf_lookup: combinational youngest-first address match.
//   ents      in  buffer entries
//   head      in  oldest entry index (scan starts here, youngest match wins)
//   skip_head in  head entry is locked (excluded from the coalesce match)
//   addr      in  lookup address
//   fwd_en    in  an incoming write to addr is accepted this cycle
//   fwd_data  in  that write's data (beats every buffered entry)
//   rd_hit/rd_data  out  read lookup result over all valid entries + forward
//   co_hit/co_idx   out  youngest unlocked matching entry for write coalesce
module mano_wbuf_lookup
  import mano_wbuf_pkg::*;
(
  input  entry_t [DEPTH-1:0] ents,
  input  logic [PTR_W-1:0]   head,
  input  logic               skip_head,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               fwd_en,
  input  logic [DATA_W-1:0]  fwd_data,
  output logic               rd_hit,
  output logic [DATA_W-1:0]  rd_data,
  output logic               co_hit,
  output logic [PTR_W-1:0]   co_idx
);
  logic [DEPTH-1:0] match;
  logic [PTR_W-1:0] p;

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign match[g] = ents[g].valid && (ents[g].addr == addr);
  end

  // Walk oldest to youngest; later assignments override, so youngest wins.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    co_hit  = 1'b0;
    co_idx  = '0;
    p       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      p = head + PTR_W'(k);
      if (match[p]) begin
        rd_hit  = 1'b1;
        rd_data = ents[p].data;
        if (!(skip_head && (p == head))) begin
          co_hit = 1'b1;
          co_idx = p;
        end
      end
    end
    if (fwd_en) begin
      rd_hit  = 1'b1;
      rd_data = fwd_data;
    end
  end
endmodule

// File: rtl/mano_wbuf.sv
// mano_wbuf: 4-entry write buffer + memory sequencer between cache and memory.
//   clk/clr               clock, synchronous active-high reset
//   c_addr/c_rd/c_wr/c_wdata  cache requests (shared address)
//   c_ready               write can be accepted (buffer not full)
//   c_rdata/c_rvalid      refill data, one-cycle valid pulse
//   m_req/m_we/m_addr/m_wdata  memory request, held until m_ack
//   m_rdata/m_ack         memory response
//   wb_full/wb_empty      buffer occupancy flags
// Refill reads take priority over write drains; a drain in flight is not preempted.
module mano_wbuf
  import mano_wbuf_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              c_rd,
  input  logic              c_wr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ready,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_rvalid,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              wb_full,
  output logic              wb_empty
);
  state_t             state_q, state_d;
  entry_t [DEPTH-1:0] ents_q, ents_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               m_req_q, m_req_d, m_we_q, m_we_d;
  logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
  logic [DATA_W-1:0]  m_wdata_q, m_wdata_d, c_rdata_q, c_rdata_d;
  logic               c_rvalid_q, c_rvalid_d;

  logic wr_acc, rd_acc, wr_coal, wr_push, wr_ack, rd_ack;
  logic rd_hit, co_hit;
  logic [DATA_W-1:0] rd_data;
  logic [PTR_W-1:0]  co_idx;

  assign wb_full  = (cnt_q == CNT_W'(DEPTH));
  assign wb_empty = (cnt_q == '0);
  assign c_ready  = !wb_full;

  assign wr_acc  = c_wr && c_ready;
  assign rd_acc  = c_rd && !rd_pend_q && !c_rvalid_q;
  assign wr_coal = wr_acc && co_hit;
  assign wr_push = wr_acc && !co_hit;
  assign wr_ack  = (state_q == WR_BUSY) && m_ack;
  assign rd_ack  = (state_q == RD_BUSY) && m_ack;

  mano_wbuf_lookup u_lookup (
    .ents      (ents_q),
    .head      (head_q),
    .skip_head (state_q == WR_BUSY),
    .addr      (c_addr),
    .fwd_en    (wr_acc),
    .fwd_data  (c_wdata),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .co_hit    (co_hit),
    .co_idx    (co_idx)
  );

  // FIFO update: coalesce, push at tail, pop head on write completion.
  always_comb begin
    ents_d = ents_q;
    head_d = head_q;
    tail_d = tail_q;
    if (wr_coal) ents_d[co_idx].data = c_wdata;
    if (wr_push) begin
      ents_d[tail_q] = '{valid: 1'b1, addr: c_addr, data: c_wdata};
      tail_d = tail_q + 1'b1;
    end
    if (wr_ack) begin
      ents_d[head_q].valid = 1'b0;
      head_d = head_q + 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(wr_push) - CNT_W'(wr_ack);
  end

  // Cache read side: buffer hit answers next cycle, miss is latched for the FSM.
  always_comb begin
    rd_pend_d  = rd_pend_q;
    rd_addr_d  = rd_addr_q;
    c_rvalid_d = 1'b0;
    c_rdata_d  = c_rdata_q;
    if (rd_acc) begin
      if (rd_hit) begin
        c_rvalid_d = 1'b1;
        c_rdata_d  = rd_data;
      end else begin
        rd_pend_d = 1'b1;
        rd_addr_d = c_addr;
      end
    end
    if (rd_ack) begin
      c_rvalid_d = 1'b1;
      c_rdata_d  = m_rdata;
      rd_pend_d  = 1'b0;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_pend_q) state_d = RD_BUSY;
               else if (!wb_empty) state_d = WR_BUSY;
      RD_BUSY: if (m_ack) state_d = IDLE;
      WR_BUSY: if (m_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs (registered memory port). A write coalescing into the head in
  // the same cycle the drain launches is forwarded so the new data goes out.
  always_comb begin
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      IDLE: begin
        if (rd_pend_q) begin
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = rd_addr_q;
        end else if (!wb_empty) begin
          m_req_d   = 1'b1;
          m_we_d    = 1'b1;
          m_addr_d  = ents_q[head_q].addr;
          m_wdata_d = (wr_coal && (co_idx == head_q)) ? c_wdata : ents_q[head_q].data;
        end
      end
      RD_BUSY, WR_BUSY: if (m_ack) m_req_d = 1'b0;
      default: m_req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ents_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      c_rdata_q  <= '0;
      c_rvalid_q <= 1'b0;
    end else begin
      ents_q     <= ents_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      c_rdata_q  <= c_rdata_d;
      c_rvalid_q <= c_rvalid_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign c_rdata  = c_rdata_q;
  assign c_rvalid = c_rvalid_q;
endmodule
